// File: rtl/out_port_arbiter_6to1.sv
// out_port_arbiter_6to1
// ---------------------------------------------------------------------------
// Switch allocator for one router output port. It arbitrates round-robin
// among six inputs that hold flits for this output, and locks the winner
// from its head flit to its tail flit. The winner's valid and flit go to the
// output link. The downstream ready is returned to the winner only.
//
// Ports:
//   clk        clock, rising edge active
//   rstn       asynchronous active-low reset
//   valid_in   [5:0]                per-input flit valid
//   data_in    [6*FLIT_WIDTH-1:0]   per-input flit, input i at [i*FLIT_WIDTH +: FLIT_WIDTH]
//   ready_out  [5:0]                per-input ready (granted input only)
//   valid_out                       flit valid toward the downstream link
//   data_out   [FLIT_WIDTH-1:0]     flit toward the downstream link
//   ready_in                        downstream ready
//   grant      [5:0]                registered one-hot (or zero) grant / ready-mux select
//
// Flit type is held in the two MSBs: 01 head, 00 body, 10 tail, 11 single.
// ---------------------------------------------------------------------------
module out_port_arbiter_6to1 #(
    parameter int unsigned FLIT_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [5:0]              valid_in,
    input  logic [6*FLIT_WIDTH-1:0] data_in,
    output logic [5:0]              ready_out,
    output logic                    valid_out,
    output logic [FLIT_WIDTH-1:0]   data_out,
    input  logic                    ready_in,
    output logic [5:0]              grant
);

    localparam int unsigned NumIn = 6;

    // Type bit FLIT_WIDTH-2 is set for head and single (packet start);
    // type bit FLIT_WIDTH-1 is set for tail and single (packet end).
    localparam int unsigned StartBit = FLIT_WIDTH - 2;
    localparam int unsigned EndBit   = FLIT_WIDTH - 1;

    logic [5:0] grant_q, grant_d;
    logic [2:0] ptr_q, ptr_d;

    logic [5:0] req;
    logic       win_found;
    logic [2:0] win_idx;
    logic [2:0] scan_idx;
    logic       pkt_end;

    // Requests: only packet-starting flits may win arbitration.
    always_comb begin
        req = '0;
        for (int i = 0; i < NumIn; i++) begin
            req[i] = valid_in[i] & data_in[i*FLIT_WIDTH + StartBit];
        end
    end

    // Round-robin search starting at ptr_q, wrapping 5 -> 0.
    always_comb begin
        win_found = 1'b0;
        win_idx   = 3'd0;
        scan_idx  = ptr_q;
        for (int k = 0; k < NumIn; k++) begin
            if (!win_found && req[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
            scan_idx = (scan_idx == 3'd5) ? 3'd0 : scan_idx + 3'd1;
        end
    end

    // Output mux driven purely by the grant register; zero when idle.
    always_comb begin
        data_out = '0;
        for (int i = 0; i < NumIn; i++) begin
            if (grant_q[i]) begin
                data_out = data_out | data_in[i*FLIT_WIDTH +: FLIT_WIDTH];
            end
        end
        valid_out = |(valid_in & grant_q);
        ready_out = grant_q & {6{ready_in}};
        pkt_end   = valid_out & ready_in & data_out[EndBit];
    end

    // Arbitrate when idle or when the locked packet ends this cycle. While
    // locked, ptr_q already points one past the holder, so the holder is
    // scanned last and only wins again if it is the sole requester.
    always_comb begin
        grant_d = grant_q;
        ptr_d   = ptr_q;
        if ((grant_q == 6'b0) || pkt_end) begin
            if (win_found) begin
                grant_d = 6'b000001 << win_idx;
                ptr_d   = (win_idx == 3'd5) ? 3'd0 : win_idx + 3'd1;
            end else begin
                grant_d = 6'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            grant_q <= 6'b0;
            ptr_q   <= 3'd0;
        end else begin
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

    assign grant = grant_q;

endmodule

// File: tb/tb_out_port_arbiter_6to1.sv
// Scoreboard bench for out_port_arbiter_6to1: the stimulus process pushes
// hand-computed expected outputs for each cycle; a monitor pops and compares
// them at the falling edge.
module tb_out_port_arbiter_6to1;

    localparam int unsigned W = 32;

    logic           clk;
    logic           rstn;
    logic [5:0]     valid_in;
    logic [6*W-1:0] data_in;
    logic [5:0]     ready_out;
    logic           valid_out;
    logic [W-1:0]   data_out;
    logic           ready_in;
    logic [5:0]     grant;

    logic [W-1:0]   din [6];

    always_comb begin
        for (int i = 0; i < 6; i++) data_in[i*W +: W] = din[i];
    end

    out_port_arbiter_6to1 #(.FLIT_WIDTH(W)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .ready_out (ready_out),
        .valid_out (valid_out),
        .data_out  (data_out),
        .ready_in  (ready_in),
        .grant     (grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      nm;
        logic [5:0] g;
        logic       v;
        logic [W-1:0] d;
        logic [5:0] r;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    localparam logic [1:0] TyHead = 2'b01;
    localparam logic [1:0] TyBody = 2'b00;
    localparam logic [1:0] TyTail = 2'b10;
    localparam logic [1:0] TySngl = 2'b11;

    function automatic logic [W-1:0] fl(input logic [1:0] t, input logic [W-3:0] p);
        return {t, p};
    endfunction

    task automatic cmp(input string nm, input string field, input logic [W-1:0] act,
                       input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s.%s actual=%h required=%h t=%0t", nm, field, act, req, $time);
        end
    endtask

    // Monitor: compares the DUT against the oldest expectation mid-cycle.
    exp_t e;
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                cmp(e.nm, "grant", W'(grant), W'(e.g));
                cmp(e.nm, "valid_out", W'(valid_out), W'(e.v));
                cmp(e.nm, "data_out", data_out, e.d);
                cmp(e.nm, "ready_out", W'(ready_out), W'(e.r));
            end
        end
    end

    // Push this cycle's expectation, then advance to just after the next edge.
    task automatic cyc(input string nm, input logic [5:0] g, input logic v,
                       input logic [W-1:0] d, input logic [5:0] r);
        exp_t x;
        x.nm = nm; x.g = g; x.v = v; x.d = d; x.r = r;
        exp_q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        valid_in = '0;
        cyc("reset", 6'b0, 1'b0, '0, 6'b0);
        rstn = 1'b1;
        cyc("reset_rel", 6'b0, 1'b0, '0, 6'b0);
    endtask

    initial begin
        rstn = 1'b0;
        ready_in = 1'b1;
        valid_in = 6'b111111;
        for (int i = 0; i < 6; i++) din[i] = fl(TyHead, 30'(i));
        @(posedge clk);
        #1;

        // Reset held with heads on every input, then first grant goes to input 0.
        cyc("rst_hold", 6'b0, 1'b0, '0, 6'b0);
        cyc("rst_hold", 6'b0, 1'b0, '0, 6'b0);
        rstn = 1'b1;
        cyc("rst_release", 6'b0, 1'b0, '0, 6'b0);
        cyc("rst_first_grant", 6'b000001, 1'b1, fl(TyHead, 30'd0), 6'b000001);
        // Asynchronous reset mid-packet drops the lock at once.
        rstn = 1'b0;
        cyc("rst_mid_packet", 6'b0, 1'b0, '0, 6'b0);
        valid_in = '0;
        rstn = 1'b1;
        cyc("idle", 6'b0, 1'b0, '0, 6'b0);

        // Single requester: input 3, head/body/body/tail, ptr starts at 0.
        valid_in = 6'b001000;
        din[3] = fl(TyHead, 30'h100);
        cyc("single_req", 6'b0, 1'b0, '0, 6'b0);
        cyc("single_head", 6'b001000, 1'b1, fl(TyHead, 30'h100), 6'b001000);
        din[3] = fl(TyBody, 30'h101);
        cyc("single_body1", 6'b001000, 1'b1, fl(TyBody, 30'h101), 6'b001000);
        din[3] = fl(TyBody, 30'h102);
        cyc("single_body2", 6'b001000, 1'b1, fl(TyBody, 30'h102), 6'b001000);
        din[3] = fl(TyTail, 30'h103);
        cyc("single_tail", 6'b001000, 1'b1, fl(TyTail, 30'h103), 6'b001000);
        valid_in = '0;
        cyc("single_done", 6'b0, 1'b0, '0, 6'b0);

        // Round-robin: all inputs stream single flits.
        do_reset();
        valid_in = 6'b111111;
        for (int i = 0; i < 6; i++) din[i] = fl(TySngl, 30'(i + 'h200));
        cyc("rr_req", 6'b0, 1'b0, '0, 6'b0);
        for (int k = 0; k < 8; k++) begin
            cyc("rr", 6'b000001 << (k % 6), 1'b1, fl(TySngl, 30'((k % 6) + 'h200)),
                6'b000001 << (k % 6));
        end

        // Packet locking: input 1 holds a 4-flit packet while input 0 waits.
        do_reset();
        valid_in = 6'b000010;
        din[1] = fl(TyHead, 30'h11);
        cyc("lock_req", 6'b0, 1'b0, '0, 6'b0);
        valid_in = 6'b000011;
        din[0] = fl(TyHead, 30'h20);
        cyc("lock_head", 6'b000010, 1'b1, fl(TyHead, 30'h11), 6'b000010);
        din[1] = fl(TyBody, 30'h12);
        cyc("lock_body1", 6'b000010, 1'b1, fl(TyBody, 30'h12), 6'b000010);
        din[1] = fl(TyBody, 30'h13);
        cyc("lock_body2", 6'b000010, 1'b1, fl(TyBody, 30'h13), 6'b000010);
        din[1] = fl(TyTail, 30'h14);
        cyc("lock_tail", 6'b000010, 1'b1, fl(TyTail, 30'h14), 6'b000010);
        valid_in = 6'b000001;
        cyc("lock_next", 6'b000001, 1'b1, fl(TyHead, 30'h20), 6'b000001);
        din[0] = fl(TyTail, 30'h21);
        cyc("lock_next_tail", 6'b000001, 1'b1, fl(TyTail, 30'h21), 6'b000001);
        valid_in = '0;
        cyc("lock_done", 6'b0, 1'b0, '0, 6'b0);

        // Backpressure on input 2 (ptr now 1).
        valid_in = 6'b000100;
        din[2] = fl(TyHead, 30'h30);
        cyc("bp_req", 6'b0, 1'b0, '0, 6'b0);
        cyc("bp_head", 6'b000100, 1'b1, fl(TyHead, 30'h30), 6'b000100);
        din[2] = fl(TyBody, 30'h31);
        ready_in = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cyc("bp_stall", 6'b000100, 1'b1, fl(TyBody, 30'h31), 6'b0);
        end
        ready_in = 1'b1;
        cyc("bp_resume", 6'b000100, 1'b1, fl(TyBody, 30'h31), 6'b000100);
        din[2] = fl(TyTail, 30'h32);
        cyc("bp_tail", 6'b000100, 1'b1, fl(TyTail, 30'h32), 6'b000100);
        valid_in = '0;
        cyc("bp_done", 6'b0, 1'b0, '0, 6'b0);

        // Ungranted body on input 4 never wins; a later head on input 2 does.
        valid_in = 6'b010000;
        din[4] = fl(TyBody, 30'h40);
        for (int k = 0; k < 4; k++) begin
            cyc("orphan_body", 6'b0, 1'b0, '0, 6'b0);
        end
        valid_in = 6'b010100;
        din[2] = fl(TyHead, 30'h50);
        cyc("orphan_head_req", 6'b0, 1'b0, '0, 6'b0);
        cyc("orphan_head", 6'b000100, 1'b1, fl(TyHead, 30'h50), 6'b000100);
        din[2] = fl(TyTail, 30'h51);
        cyc("orphan_tail", 6'b000100, 1'b1, fl(TyTail, 30'h51), 6'b000100);
        valid_in = 6'b010000;
        cyc("orphan_after", 6'b0, 1'b0, '0, 6'b0);
        valid_in = '0;

        // Let the monitor drain, bounded.
        for (int k = 0; k < 4 && exp_q.size() != 0; k++) @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/out_port_arbiter_6to1.md
# out_port_arbiter_6to1

Per-output-port switch allocator for the router crossbar. It arbitrates among six input ports that hold flits for this output using round-robin, and locks the winner for a whole packet (head to tail). It forwards the winner's valid and flit to the output link and returns the downstream ready to the winner only. Its registered one-hot grant is the select that steers the output's ready back toward the winning input.

## Interface

- FLIT_WIDTH, 32: flit width in bits; type field is the two MSBs [FLIT_WIDTH-1:FLIT_WIDTH-2]: 2'b01 head, 2'b00 body, 2'b10 tail, 2'b11 single (head+tail).
- clk  input  1  clock; all state changes on the rising edge.
- rstn  input  1  reset, asynchronous, active-low.
- valid_in  input  6  per-input flit valid.
- data_in  input  6*FLIT_WIDTH  per-input flit; input i occupies bits [i*FLIT_WIDTH +: FLIT_WIDTH].
- ready_out  output  6  per-input ready; only the granted input can see 1.
- valid_out  output  1  flit valid toward the downstream link.
- data_out  output  FLIT_WIDTH  flit toward the downstream link.
- ready_in  input  1  downstream ready.
- grant  output  6  registered one-hot (or zero) grant; doubles as the ready-mux select.

## Operation

- State: grant register (6b, one-hot or 0) and round-robin pointer ptr (3b, 0..5).
- IDLE (grant == 0):
  - Request r[i] = valid_in[i] & (type is head or single).
  - If any r[i] is set, the winner is the first set r[i] scanning i = ptr, ptr+1, …, 5, 0, …, ptr-1 (mod 6).
  - On the next edge, grant = onehot(winner) and ptr = (winner+1) mod 6.
  - valid_out = 0, ready_out = 0 while grant == 0.
- LOCKED (grant[g] == 1):
  - valid_out = valid_in[g], data_out = data_in[g].
  - ready_out[g] = ready_in; every other ready_out bit is 0.
  - Transfer = valid_out & ready_in.
  - Transfer of a tail or single flit ends the packet. In that same cycle the arbiter re-arbitrates over r[] with the updated pointer (winner+1 from the lock). The edge loads the new grant, or 0 if there are no requests.
  - A packet-ending transfer never re-grants the same input back-to-back unless it is the only requester.
- Body/tail flits on an ungranted input are ignored. They get no grant and no ready; they stall until a grant exists.
- A head flit arriving on the granted input mid-packet is a protocol error. It is forwarded unchanged and does not end the lock.
- Pointer width arithmetic: wrap 5 -> 0 explicitly; ptr never holds 6 or 7.
- data_out = 0 when grant == 0.

## Timing

- Reset (rstn low, asynchronous): grant = 6'b0, ptr = 0, ready_out = 0, valid_out = 0, data_out = 0. Release takes effect on the first clk edge after rstn goes high.
- Grant latency: a request seen in cycle N gives grant in cycle N+1. The first flit can transfer in N+1 if ready_in = 1.
- Back-to-back packets: a tail transfer in cycle T gives the new grant in T+1, with no idle bubble.
- valid_out, data_out and ready_out are combinational from the grant register plus the inputs. There is no combinational path from valid_in to grant.
- Reset asserted mid-packet: the lock is dropped immediately and the packet is abandoned. Upstream and downstream must also be reset.
- ready_in low holds the lock indefinitely; the grant never changes without a tail transfer.

## Test plan

- Reset: hold rstn = 0 with all valid_in = 1 and head flits present -> grant = 0, valid_out = 0, ready_out = 0. After release, cycle 1 shows grant = 6'b000001.
- Single requester: head on input 3 in cycle 0; body, body, tail with ready_in = 1 -> grant = 6'b001000 from cycle 1. data_out matches input 3's four flits in cycles 1-4. grant = 0 in cycle 5.
- Round-robin fairness: all six inputs continuously send single flits, ready_in = 1 -> grant sequence 0,1,2,3,4,5,0,… with one transfer per cycle after the first.
- Packet locking: input 1 holds a 4-flit packet while input 0 presents a head -> grant stays 6'b000010 until input 1's tail transfers. Next cycle grant = 6'b000001.
- Backpressure: ready_in = 0 for 5 cycles mid-packet -> valid_out stays 1, data_out stable, grant unchanged, ready_out = 0. Transfer resumes when ready_in = 1.
- Ungranted body flit: body flit valid on input 4 while idle -> no grant, ready_out[4] = 0 indefinitely. A later head on input 2 is granted normally.
